score_display_ctrl: RTL

- Scheduler/controller for the on-screen seven-segment score overlay in the VGA pong datapath.
- Owns a two-digit BCD score counter and latches the displayed digits only at frame boundaries, which prevents tearing.
- Runs a blink state machine after each score change.
- Arbitrates each pixel between the game renderer and two VGA7SegDisplay digit units (tens, units), with fixed digit priority.
- Sits between video_timer/game/VGA7SegDisplay instances and the VGA colour pins.

---
 rtl/score_display_ctrl_if.sv | 35 +++
 rtl/score_display_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/score_display_ctrl_if.sv
// Bundles the video, score-control and colour signals of the score overlay.
// The master side drives timing, score pulses and game/digit pixels; the slave side returns positions, digits and colour.
interface score_display_ctrl_if;
  logic       vsync;
  logic       score_inc;
  logic       score_clr;
  logic       pix_tens;
  logic       pix_units;
  logic [2:0] red_game;
  logic [2:0] green_game;
  logic [1:0] blue_game;
  logic [9:0] Digit1X;
  logic [9:0] Digit1Y;
  logic [9:0] Digit0X;
  logic [9:0] Digit0Y;
  logic [3:0] Number1;
  logic [3:0] Number0;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;

  modport master (
    output vsync, score_inc, score_clr, pix_tens, pix_units,
    output red_game, green_game, blue_game,
    input  Digit1X, Digit1Y, Digit0X, Digit0Y, Number1, Number0,
    input  red, green, blue
  );

  modport slave (
    input  vsync, score_inc, score_clr, pix_tens, pix_units,
    input  red_game, green_game, blue_game,
    output Digit1X, Digit1Y, Digit0X, Digit0Y, Number1, Number0,
    output red, green, blue
  );
endinterface

// File: rtl/score_display_ctrl.sv
// Two-digit BCD score with frame-synchronous digit latch, post-change blink FSM and digit-over-game pixel mux.
// Score/digits/FSM update one cycle after their trigger; colour mux is combinational (zero latency); no backpressure.
module score_display_ctrl #(
  parameter logic [9:0] BASE_X      = 10'd200,
  parameter logic [9:0] BASE_Y      = 10'd20,
  parameter logic [9:0] DIGIT_PITCH = 10'd40,
  parameter int         BLINK_HALF  = 8,
  parameter int         BLINK_COUNT = 3,
  parameter int         LEAD_BLANK  = 1,
  parameter logic [7:0] DIGIT_RGB   = 8'b101_101_10
) (
  input  logic                 clk25,
  input  logic                 reset,
  score_display_ctrl_if.slave  bus
);

  localparam logic [7:0] HALF_LAST  = 8'(BLINK_HALF - 1);
  localparam logic [3:0] CYCLES_INI = 4'(BLINK_COUNT);

  typedef enum logic [1:0] {IDLE, BLINK_ON, BLINK_OFF} state_t;

  state_t     state_q;
  logic [7:0] frame_cnt_q;
  logic [3:0] cycles_left_q;
  logic       visible_q;
  logic       vsync_q;
  logic [3:0] tens_q, units_q, tens_d, units_d;
  logic [3:0] num1_q, num0_q;
  logic       score_chg;
  logic       frame_tick;
  logic       tens_on;
  logic       digit_px;

  assign frame_tick = vsync_q & ~bus.vsync;

  // A saturated increment leaves the score alone and must not count as a change.
  always_comb begin
    tens_d    = tens_q;
    units_d   = units_q;
    score_chg = 1'b0;
    if (bus.score_clr) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (bus.score_inc && !(tens_q == 4'd9 && units_q == 4'd9)) begin
      score_chg = 1'b1;
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      vsync_q       <= 1'b1;
      tens_q        <= 4'd0;
      units_q       <= 4'd0;
      num1_q        <= 4'd0;
      num0_q        <= 4'd0;
      state_q       <= IDLE;
      visible_q     <= 1'b1;
      frame_cnt_q   <= 8'd0;
      cycles_left_q <= 4'd0;
    end else begin
      vsync_q <= bus.vsync;
      tens_q  <= tens_d;
      units_q <= units_d;
      if (frame_tick) begin
        num1_q <= tens_q;
        num0_q <= units_q;
      end
      if (bus.score_clr) begin
        state_q       <= IDLE;
        visible_q     <= 1'b1;
        frame_cnt_q   <= 8'd0;
        cycles_left_q <= 4'd0;
      end else if (score_chg) begin
        state_q       <= BLINK_ON;
        visible_q     <= 1'b1;
        frame_cnt_q   <= 8'd0;
        cycles_left_q <= CYCLES_INI;
      end else if (frame_tick) begin
        case (state_q)
          BLINK_ON: begin
            if (frame_cnt_q == HALF_LAST) begin
              state_q     <= BLINK_OFF;
              visible_q   <= 1'b0;
              frame_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
          BLINK_OFF: begin
            if (frame_cnt_q == HALF_LAST) begin
              frame_cnt_q   <= 8'd0;
              visible_q     <= 1'b1;
              cycles_left_q <= cycles_left_q - 4'd1;
              state_q       <= (cycles_left_q == 4'd1) ? IDLE : BLINK_ON;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
          IDLE: begin
            visible_q <= 1'b1;
          end
          default: begin
            state_q   <= IDLE;
            visible_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.Digit1X = BASE_X;
  assign bus.Digit1Y = BASE_Y;
  assign bus.Digit0X = BASE_X + DIGIT_PITCH;
  assign bus.Digit0Y = BASE_Y;
  assign bus.Number1 = num1_q;
  assign bus.Number0 = num0_q;

  // Digit pixels replace the game colour outright rather than blending with it.
  assign tens_on  = bus.pix_tens & ~((LEAD_BLANK != 0) && (num1_q == 4'd0));
  assign digit_px = visible_q & (tens_on | bus.pix_units);
  assign {bus.red, bus.green, bus.blue} =
      digit_px ? DIGIT_RGB : {bus.red_game, bus.green_game, bus.blue_game};

endmodule
